// File: rtl/axi4s_prbs_checker_pkg.sv
// Shared LFSR definitions: checker state codes and the unrolled Fibonacci step used by
// both the PRBS generator and the checker.
package axi4s_prbs_checker_pkg;

    localparam int unsigned MAX_DEG   = 32;
    localparam int unsigned DEG_IDX_W = 5;
    localparam int unsigned MAX_W     = 128;
    localparam int unsigned W_IDX_W   = 7;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // state[degree-1] is the newest sequence bit; word bit 0 is the first bit produced.
    function automatic logic [MAX_W-1:0] lfsr_next_word(
        input logic [MAX_DEG-1:0] state,
        input logic [MAX_DEG-1:0] poly,
        input int unsigned        degree,
        input int unsigned        width
    );
        logic [MAX_DEG-1:0] hist;
        logic [MAX_W-1:0]   word;
        logic               fb;
        hist = state;
        word = '0;
        for (int unsigned j = 0; j < MAX_W; j++) begin
            if (j < width) begin
                fb = 1'b0;
                for (int unsigned i = 0; i < MAX_DEG; i++) begin
                    if (i < degree && poly[DEG_IDX_W'(i)]) begin
                        fb = fb ^ hist[DEG_IDX_W'(degree - 1 - i)];
                    end
                end
                hist                         = hist >> 1;
                hist[DEG_IDX_W'(degree - 1)] = fb;
                word[W_IDX_W'(j)]            = fb;
            end
        end
        return word;
    endfunction

    // Top degree bits of the produced word become the new state.
    function automatic logic [MAX_DEG-1:0] lfsr_next_state(
        input logic [MAX_W-1:0] word,
        input int unsigned      degree,
        input int unsigned      width
    );
        logic [MAX_DEG-1:0] ns;
        ns = '0;
        for (int unsigned k = 0; k < MAX_DEG; k++) begin
            if (k < degree) begin
                ns[DEG_IDX_W'(k)] = word[W_IDX_W'(width - degree + k)];
            end
        end
        return ns;
    endfunction

endpackage

// File: rtl/lfsr_word_step.sv
// Combinational unrolled LFSR step: predicted beat and successor state for a given state.
module lfsr_word_step
    import axi4s_prbs_checker_pkg::*;
#(
    parameter int unsigned             POLY_DEGREE = 7,
    parameter logic [POLY_DEGREE-1:0]  POLYNOMIAL  = 7'b1100000,
    parameter int unsigned             TDATA_WIDTH = 8
) (
    input  logic [POLY_DEGREE-1:0] state_i,
    output logic [TDATA_WIDTH-1:0] word_c_o,
    output logic [POLY_DEGREE-1:0] next_state_c_o
);

    logic [MAX_W-1:0] full_word;

    always_comb begin
        full_word      = lfsr_next_word(MAX_DEG'(state_i), MAX_DEG'(POLYNOMIAL),
                                        POLY_DEGREE, TDATA_WIDTH);
        word_c_o       = TDATA_WIDTH'(full_word);
        next_state_c_o = POLY_DEGREE'(lfsr_next_state(full_word, POLY_DEGREE, TDATA_WIDTH));
    end

endmodule

// File: rtl/axi4s_prbs_checker.sv
// AXI4-Stream PRBS checker: self-synchronises to an LFSR stream, then counts beats and errors.
// Define AXI4S_PRBS_CHECKER_BIT_ERRORS_EN to count errored bits instead of errored beats.
module axi4s_prbs_checker
    import axi4s_prbs_checker_pkg::*;
#(
    parameter int unsigned             POLY_DEGREE   = 7,
    parameter logic [POLY_DEGREE-1:0]  POLYNOMIAL    = 7'b1100000,
    parameter int unsigned             TDATA_WIDTH   = 8,
    parameter int unsigned             LOCK_COUNT    = 4,
    parameter int unsigned             UNLOCK_ERRORS = 4,
    parameter int unsigned             CNT_WIDTH     = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   target_tvalid,
    output logic                   target_tready,
    input  logic [TDATA_WIDTH-1:0] target_tdata,
    input  logic                   target_tlast,
    input  logic                   clear,
    output logic                   locked,
    output logic                   error,
    output logic [CNT_WIDTH-1:0]   beat_cnt,
    output logic [CNT_WIDTH-1:0]   error_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_ERRORS + 1);
    localparam int unsigned PC_W   = $clog2(TDATA_WIDTH + 1);
    localparam int unsigned SUM_W  = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

    if (TDATA_WIDTH < POLY_DEGREE || POLY_DEGREE < 2 || POLY_DEGREE > MAX_DEG ||
        TDATA_WIDTH > MAX_W || LOCK_COUNT < 1 || UNLOCK_ERRORS < 1) begin : g_bad_cfg
        $error("axi4s_prbs_checker: illegal parameter combination");
    end

    logic [1:0]             fsm_q, fsm_d;
    logic [POLY_DEGREE-1:0] state_q, state_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [BAD_W-1:0]       bad_q, bad_d;
    logic                   tready_q, locked_q, locked_d, error_q, error_d;
    logic [CNT_WIDTH-1:0]   beat_q, beat_d, errcnt_q, errcnt_d;

    logic [TDATA_WIDTH-1:0] pred_word;
    logic [POLY_DEGREE-1:0] pred_next, seed;
    logic                   accept, mismatch, beat_inc, err_inc;
    logic [PC_W-1:0]        err_weight;
    logic                   unused_tlast;

    assign unused_tlast = target_tlast;
    assign accept       = target_tvalid && tready_q;
    assign mismatch     = (target_tdata != pred_word);
    assign seed         = target_tdata[TDATA_WIDTH-1 -: POLY_DEGREE];

    lfsr_word_step #(
        .POLY_DEGREE (POLY_DEGREE),
        .POLYNOMIAL  (POLYNOMIAL),
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_step (
        .state_i        (state_q),
        .word_c_o       (pred_word),
        .next_state_c_o (pred_next)
    );

`ifdef AXI4S_PRBS_CHECKER_BIT_ERRORS_EN
    logic [TDATA_WIDTH-1:0] diff;
    assign diff = target_tdata ^ pred_word;
    always_comb begin
        err_weight = '0;
        for (int unsigned b = 0; b < TDATA_WIDTH; b++) begin
            err_weight = err_weight + PC_W'(diff[b]);
        end
    end
`else
    assign err_weight = PC_W'(1);
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [PC_W-1:0]      b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        return (sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(sum);
    endfunction

    // Next-state and output logic; in LOCKED the state always follows the prediction.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        good_d   = good_q;
        bad_d    = bad_q;
        error_d  = 1'b0;
        beat_inc = 1'b0;
        err_inc  = 1'b0;
        case (fsm_q)
            ST_HUNT: begin
                if (accept) begin
                    state_d = seed;
                    good_d  = '0;
                    fsm_d   = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (accept) begin
                    if (mismatch) begin
                        state_d = seed;
                        good_d  = '0;
                    end else begin
                        state_d = pred_next;
                        if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            good_d = '0;
                            bad_d  = '0;
                            fsm_d  = ST_LOCKED;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    state_d  = pred_next;
                    beat_inc = 1'b1;
                    if (mismatch) begin
                        error_d = 1'b1;
                        err_inc = 1'b1;
                        if (bad_q == BAD_W'(UNLOCK_ERRORS - 1)) begin
                            bad_d = '0;
                            fsm_d = ST_HUNT;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            end
            default: fsm_d = ST_HUNT;
        endcase
        locked_d = (fsm_d == ST_LOCKED);
        beat_d   = clear ? '0 : (beat_inc ? sat_add(beat_q, PC_W'(1)) : beat_q);
        errcnt_d = clear ? '0 : (err_inc ? sat_add(errcnt_q, err_weight) : errcnt_q);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            fsm_q    <= ST_HUNT;
            state_q  <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            tready_q <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            beat_q   <= '0;
            errcnt_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            tready_q <= 1'b1;
            locked_q <= locked_d;
            error_q  <= error_d;
            beat_q   <= beat_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign target_tready = tready_q;
    assign locked        = locked_q;
    assign error         = error_q;
    assign beat_cnt      = beat_q;
    assign error_cnt     = errcnt_q;

endmodule

// File: tb/tb_axi4s_prbs_checker.sv
// Scoreboard bench for axi4s_prbs_checker: random PRBS7 stream with injected errors, gaps,
// clears and resets, checked each cycle against a bit-level reference model.
module tb_axi4s_prbs_checker;

    localparam int unsigned DEG     = 7;
    localparam logic [6:0]  POLY    = 7'b1100000;
    localparam int unsigned W       = 8;
    localparam int          LOCKN   = 4;
    localparam int          UNLOCKN = 4;
    localparam longint      MAX_A   = 64'd4294967295;
    localparam longint      MAX_B   = 64'd15;

    logic        aclk = 1'b0;
    logic        areset, tvalid, tlast, clear;
    logic [7:0]  tdata;
    logic        tready_a, locked_a, error_a, tready_b, locked_b, error_b;
    logic [31:0] beat_a, errc_a;
    logic [3:0]  beat_b, errc_b;

    always #5 aclk = ~aclk;

    axi4s_prbs_checker #(.POLY_DEGREE(DEG), .POLYNOMIAL(POLY), .TDATA_WIDTH(W),
        .LOCK_COUNT(LOCKN), .UNLOCK_ERRORS(UNLOCKN), .CNT_WIDTH(32)) dut_a (
        .aclk(aclk), .areset(areset), .target_tvalid(tvalid), .target_tready(tready_a),
        .target_tdata(tdata), .target_tlast(tlast), .clear(clear), .locked(locked_a),
        .error(error_a), .beat_cnt(beat_a), .error_cnt(errc_a));

    axi4s_prbs_checker #(.POLY_DEGREE(DEG), .POLYNOMIAL(POLY), .TDATA_WIDTH(W),
        .LOCK_COUNT(LOCKN), .UNLOCK_ERRORS(UNLOCKN), .CNT_WIDTH(4)) dut_b (
        .aclk(aclk), .areset(areset), .target_tvalid(tvalid), .target_tready(tready_b),
        .target_tdata(tdata), .target_tlast(tlast), .clear(clear), .locked(locked_b),
        .error(error_b), .beat_cnt(beat_b), .error_cnt(errc_b));

    typedef struct {
        bit     tready;
        bit     locked;
        bit     error;
        longint beats;
        longint errs;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;

    // Reference model: history bits with hist[k] = bit k+1 steps in the past.
    int          m_mode;
    logic [63:0] m_hist, gen_hist;
    int          m_good, m_bad;
    longint      m_beats, m_errs;
    bit          m_tready;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [7:0] predict(input logic [63:0] hist_in, output logic [63:0] hist_out);
        logic [63:0] h;
        logic [6:0]  poly_v;
        logic [7:0]  w;
        bit          nb;
        h      = hist_in;
        poly_v = POLY;
        w      = '0;
        for (int j = 0; j < W; j++) begin
            nb = 1'b0;
            for (int i = 0; i < DEG; i++) if (poly_v[i]) nb ^= h[i];
            h    = {h[62:0], nb};
            w[j] = nb;
        end
        hist_out = h;
        return w;
    endfunction

    function automatic logic [63:0] seed_from(input logic [7:0] d);
        logic [63:0] h;
        h = '0;
        for (int k = 0; k < DEG; k++) h[k] = d[W-1-k];
        return h;
    endfunction

    task automatic model_step();
        exp_t        e;
        logic [63:0] nh;
        logic [7:0]  pw;
        longint      db, de;
        e.error = 1'b0;
        if (areset) begin
            m_mode = 0; m_hist = '0; m_good = 0; m_bad = 0;
            m_beats = 0; m_errs = 0; m_tready = 1'b0;
        end else begin
            db = 0; de = 0;
            pw = predict(m_hist, nh);
            if (tvalid && m_tready) begin
                case (m_mode)
                    0: begin m_hist = seed_from(tdata); m_good = 0; m_mode = 1; end
                    1: begin
                        if (tdata == pw) begin
                            m_hist = nh; m_good++;
                            if (m_good == LOCKN) begin m_mode = 2; m_bad = 0; end
                        end else begin
                            m_hist = seed_from(tdata); m_good = 0;
                        end
                    end
                    default: begin
                        m_hist = nh; db = 1;
                        if (tdata != pw) begin
                            e.error = 1'b1;
`ifdef AXI4S_PRBS_CHECKER_BIT_ERRORS_EN
                            de = $countones(tdata ^ pw);
`else
                            de = 1;
`endif
                            m_bad++;
                            if (m_bad == UNLOCKN) begin m_mode = 0; m_bad = 0; end
                        end else begin
                            m_bad = 0;
                        end
                    end
                endcase
            end
            if (clear) begin m_beats = 0; m_errs = 0; end
            else begin m_beats += db; m_errs += de; end
            m_tready = 1'b1;
        end
        e.tready = m_tready;
        e.locked = (m_mode == 2);
        e.beats  = m_beats;
        e.errs   = m_errs;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] gen_word();
        logic [63:0] nh;
        logic [7:0]  w;
        w        = predict(gen_hist, nh);
        gen_hist = nh;
        return w;
    endfunction

    task automatic drive(input bit rst, input bit v, input logic [7:0] d, input bit clr);
        @(negedge aclk);
        areset = rst;
        tvalid = v;
        tdata  = d;
        tlast  = 1'($urandom);
        clear  = clr;
        model_step();
    endtask

    task automatic beat(input logic [7:0] mask, input bit clr);
        drive(1'b0, 1'b1, gen_word() ^ mask, clr);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    function automatic logic [7:0] rmask();
        return 8'($urandom_range(1, 255));
    endfunction

    // Monitor: compare both instances against the oldest expectation every cycle.
    always @(posedge aclk) begin : monitor
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tready_a", longint'(tready_a), longint'(e.tready));
            check("locked_a", longint'(locked_a), longint'(e.locked));
            check("error_a",  longint'(error_a),  longint'(e.error));
            check("beat_cnt_a",  longint'(beat_a), sat(e.beats, MAX_A));
            check("error_cnt_a", longint'(errc_a), sat(e.errs, MAX_A));
            check("tready_b", longint'(tready_b), longint'(e.tready));
            check("locked_b", longint'(locked_b), longint'(e.locked));
            check("error_b",  longint'(error_b),  longint'(e.error));
            check("beat_cnt_b",  longint'(beat_b), sat(e.beats, MAX_B));
            check("error_cnt_b", longint'(errc_b), sat(e.errs, MAX_B));
        end
    end

    initial begin
        areset = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; clear = 1'b0;
        gen_hist = 64'($urandom_range(1, 127));
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);

        // clean acquisition, then single-beat errors of 1 and 3 bits
        repeat (20) beat(8'h00, 1'b0);
        beat(8'h08, 1'b0);
        repeat (6) beat(8'h00, 1'b0);
        beat(8'h29, 1'b0);
        repeat (6) beat(8'h00, 1'b0);

        // four bad beats drop lock, then relock
        repeat (4) beat(rmask(), 1'b0);
        repeat (8) beat(8'h00, 1'b0);

        // corruption while verifying
        repeat (2) drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) beat(8'h00, 1'b0);
        beat(rmask(), 1'b0);
        repeat (10) beat(8'h00, 1'b0);

        // random gaps, errors and clears
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) idle();
            else beat(($urandom_range(0, 5) == 0) ? rmask() : 8'h00, $urandom_range(0, 19) == 0);
        end

        // saturation of the narrow counters while keeping lock, then clear on an errored beat
        repeat (10) beat(8'h00, 1'b0);
        repeat (10) begin
            repeat (3) beat(rmask(), 1'b0);
            beat(8'h00, 1'b0);
        end
        beat(rmask(), 1'b1);
        repeat (3) beat(8'h00, 1'b0);

        // reset while locked with a beat presented
        repeat (8) beat(8'h00, 1'b0);
        drive(1'b1, 1'b1, gen_word(), 1'b0);
        repeat (12) beat(8'h00, 1'b0);
        repeat (2) idle();

        @(negedge aclk);
        @(negedge aclk);
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi4s_prbs_checker.md
# axi4s_prbs_checker

Receive-side AXI4-Stream PRBS checker, the counterpart of the LFSR stream generator. It sits at the sink end of a link or loopback under test and self-synchronises to an incoming LFSR sequence. Once locked, it predicts every beat, compares it against the received data and reports lock status and error counts. It is a pure sink with no initiator port.

## Interface
- POLY_DEGREE, 7, LFSR degree (≥2)
- POLYNOMIAL, 7'b1100000, feedback taps of the generator (bit i = tap x^(i+1)); default is PRBS7, x^7+x^6+1
- TDATA_WIDTH, 8, beat width; must be ≥ POLY_DEGREE (elaboration-time assertion)
- LOCK_COUNT, 4, consecutive correct beats in VERIFY required to declare lock (≥1)
- UNLOCK_ERRORS, 4, consecutive erroneous beats in LOCKED that drop lock (≥1)
- CNT_WIDTH, 32, width of beat_cnt and error_cnt
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- target_tvalid  in  1  beat valid
- target_tready  out  1  beat ready
- target_tdata  in  TDATA_WIDTH  received PRBS data; bit 0 is earliest in sequence
- target_tlast  in  1  accepted and ignored
- clear  in  1  synchronous pulse; zeroes beat_cnt and error_cnt
- locked  out  1  high while in LOCKED
- error  out  1  one-cycle pulse per erroneous beat checked in LOCKED
- beat_cnt  out  CNT_WIDTH  beats checked while LOCKED, saturating
- error_cnt  out  CNT_WIDTH  error count (see Configuration), saturating

Decided: one clock, aclk; reset areset is synchronous and active-high.

## Operation
- Acceptance is a beat with target_tvalid && target_tready. target_tready is 0 during reset and constant 1 otherwise.
- Prediction:
  - State s holds the last POLY_DEGREE sequence bits.
  - next_word(s) unrolls TDATA_WIDTH Fibonacci steps, LSB first.
  - next_state is the top POLY_DEGREE bits of the resulting word.
- FSM states are HUNT, VERIFY and LOCKED. Reset state is HUNT.
  - HUNT: on accept, seed s from the top POLY_DEGREE bits of tdata, set good_cnt=0 and go to VERIFY.
  - VERIFY: on accept, compare tdata with next_word(s).
    - Match: s←next_state and good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: reseed s from tdata, set good_cnt=0 and stay in VERIFY.
  - LOCKED: on accept, s←next_state, always taken from the prediction and never from the data, so errors do not propagate.
    - beat_cnt++ on every accepted beat.
    - Mismatch: pulse error, add to error_cnt and increment bad_cnt.
    - Match: bad_cnt=0.
    - When bad_cnt reaches UNLOCK_ERRORS, go to HUNT and clear bad_cnt.
- Both counters saturate at all-ones and never wrap.
- clear together with a counted beat: clear wins and that beat's contribution is discarded. The FSM is unaffected by clear.
- No beat accepted: state, counters and the FSM hold.

## Timing
- All outputs are registered and reflect an accepted beat on the following cycle.
- Reset values: target_tready=0, locked=0, error=0, beat_cnt=0, error_cnt=0; FSM in HUNT with s=0.
- Reset mid-stream: return to HUNT on the next edge and drop lock. Any beat presented during reset is not accepted.
- Latency, error-free stream: HUNT 1 beat, then LOCK_COUNT VERIFY beats. locked rises 1 cycle after beat number LOCK_COUNT+1.
- Gaps in tvalid do not affect checking.

## Configuration
- AXI4S_PRBS_CHECKER_BIT_ERRORS_EN:
  - Defined: error_cnt adds popcount(tdata XOR prediction) per erroneous beat, saturating on the sum.
  - Undefined: error_cnt adds 1 per erroneous beat and the popcount logic is absent.
  - error and locked behave identically in both builds.

## Structure
- The checker state enum and the unrolled next_word/next_state function go in the shared LFSR package, so the generator and checker use one step definition.
- One sub-module, lfsr_word_step: combinational unrolled step with outputs word and next_state.

## Test plan
- Error-free PRBS7 stream, 20 beats, continuous tvalid. Required: locked rises 1 cycle after beat 5, beat_cnt=15, error_cnt=0, error never pulses.
- After lock, flip bit 3 of one beat:
  - required: a single error pulse and error_cnt=1 in both builds;
  - with the macro defined, flipping 3 bits in one beat gives error_cnt=3, and without it error_cnt=1;
  - lock is held.
- After lock, send 4 consecutive random beats. Required: locked falls after the 4th, then relock takes 5 clean beats.
- In VERIFY, corrupt beat 3. Required: reseed, and locked rises only after 4 further consecutive matches.
- Set CNT_WIDTH=4 with a continuous error stream. Required: counters saturate at 15. Assert clear on the same cycle as an errored beat: both counters read 0 next cycle.
- Pulse areset while locked with tvalid high. Required: next cycle locked=0, tready=0, counters 0, then re-acquisition from HUNT.
